// File: rtl/sd_sched_pkg.sv
// Shared definitions for the packet-aware FIFO scheduler.
//   sched_state_t : FSM states (S_IDLE = between packets, S_LOCK = mid-packet)
//   wrap_inc      : increment modulo n, for index counters whose range is not
//                   a power of two
package sd_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } sched_state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Rotating-priority picker: finds the first set bit of req, searching upward
// from ptr+1 and wrapping from inputs-1 back to 0.
//   req   : request vector
//   ptr   : last-granted index (highest priority goes to ptr+1)
//   sel   : chosen index; ptr+1 (wrapped) when nothing is requesting
//   found : at least one request bit is set
module sd_rr_pick
    import sd_sched_pkg::*;
#(
    parameter int inputs = 4,
    parameter int isz    = $clog2(inputs)
) (
    input  logic [inputs-1:0] req,
    input  logic [isz-1:0]    ptr,
    output logic [isz-1:0]    sel,
    output logic              found
);

    // Walk from the farthest candidate to the nearest so the nearest match
    // is the last one written.
    always_comb begin
        int idx;
        sel   = isz'(wrap_inc(int'(ptr), inputs));
        found = 1'b0;
        for (int k = inputs; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= inputs) begin
                idx = idx - inputs;
            end
            if (req[idx]) begin
                sel   = isz'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_fifo_sched.sv
// Packet-aware round-robin scheduler in front of a shared FIFO. Requesters
// win arbitration on their first word and keep the grant until eop.
// Datapath is a pure mux; only rr_ptr, lock_sel and the FSM state are stored.
//   clk, reset          : clock, async active-low reset
//   c_srdy/c_drdy       : per-requester valid / accept
//   c_data, c_eop       : per-requester word and last-word flag
//   p_srdy/p_drdy       : selected word valid / FIFO ready
//   p_data, p_eop       : selected word and last-word flag
//   p_tag               : index of the selected requester
//   p_lock              : packet in progress
module sd_fifo_sched
    import sd_sched_pkg::*;
#(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int isz    = $clog2(inputs)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs-1:0]         c_srdy,
    output logic [inputs-1:0]         c_drdy,
    input  logic [inputs*width-1:0]   c_data,
    input  logic [inputs-1:0]         c_eop,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [width-1:0]          p_data,
    output logic                      p_eop,
    output logic [isz-1:0]            p_tag,
    output logic                      p_lock
);

    sched_state_t   state_q, state_d;
    logic [isz-1:0] rr_ptr_q, rr_ptr_d;
    logic [isz-1:0] lock_sel_q, lock_sel_d;

    logic [isz-1:0] pick_sel;
    logic           pick_found;
    logic [isz-1:0] sel;
    logic           xfer;

    sd_rr_pick #(
        .inputs (inputs),
        .isz    (isz)
    ) u_pick (
        .req   (c_srdy),
        .ptr   (rr_ptr_q),
        .sel   (pick_sel),
        .found (pick_found)
    );

    assign sel    = (state_q == S_LOCK) ? lock_sel_q : pick_sel;
    // In idle, c_srdy[pick_sel] is exactly pick_found.
    assign p_srdy = (state_q == S_LOCK) ? c_srdy[lock_sel_q] : pick_found;
    assign p_data = c_data[sel*width +: width];
    assign p_eop  = c_eop[sel];
    assign p_tag  = sel;
    assign p_lock = (state_q == S_LOCK);
    assign xfer   = p_srdy & p_drdy;

    always_comb begin
        c_drdy      = '0;
        c_drdy[sel] = p_drdy;
    end

    // Grant is committed only on an actual transfer, so stalls never cost a
    // requester its turn.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_sel_d = lock_sel_q;
        if (xfer) begin
            case (state_q)
                S_IDLE: begin
                    rr_ptr_d = sel;
                    if (!p_eop) begin
                        state_d    = S_LOCK;
                        lock_sel_d = sel;
                    end
                end
                S_LOCK: begin
                    if (p_eop) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= isz'(inputs - 1);
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_sel_q <= lock_sel_d;
        end
    end

endmodule

// File: tb/tb_sd_fifo_sched.sv
module tb_sd_fifo_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // 4-requester instance
    logic [3:0]  c_srdy = '0;
    logic [3:0]  c_drdy;
    logic [31:0] c_data = '0;
    logic [3:0]  c_eop = '0;
    logic        p_srdy;
    logic        p_drdy = 1'b0;
    logic [7:0]  p_data;
    logic        p_eop;
    logic [1:0]  p_tag;
    logic        p_lock;

    // 3-requester instance (non-power-of-2)
    logic [2:0]  c3_srdy = '0;
    logic [2:0]  c3_drdy;
    logic [23:0] c3_data = '0;
    logic [2:0]  c3_eop = '0;
    logic        p3_srdy;
    logic        p3_drdy = 1'b0;
    logic [7:0]  p3_data;
    logic        p3_eop;
    logic [1:0]  p3_tag;
    logic        p3_lock;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_fifo_sched #(.width(8), .inputs(4)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop),
        .p_tag(p_tag), .p_lock(p_lock)
    );

    sd_fifo_sched #(.width(8), .inputs(3)) dut3 (
        .clk(clk), .reset(reset),
        .c_srdy(c3_srdy), .c_drdy(c3_drdy), .c_data(c3_data), .c_eop(c3_eop),
        .p_srdy(p3_srdy), .p_drdy(p3_drdy), .p_data(p3_data), .p_eop(p3_eop),
        .p_tag(p3_tag), .p_lock(p3_lock)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: who was granted last, whether a packet is open and by whom.
    int nreq[2]    = '{4, 3};
    int m_last[2]  = '{3, 2};
    int m_owner[2] = '{0, 0};
    bit m_lock[2]  = '{1'b0, 1'b0};

    function automatic int exp_sel(input int inst, input logic [3:0] req);
        int n;
        n = nreq[inst];
        if (m_lock[inst]) return m_owner[inst];
        for (int k = 1; k <= n; k++) begin
            if (req[(m_last[inst] + k) % n]) return (m_last[inst] + k) % n;
        end
        return (m_last[inst] + 1) % n;
    endfunction

    function automatic void model_step(input int inst, input logic [3:0] req,
                                       input logic [3:0] eop, input logic drdy);
        int s;
        s = exp_sel(inst, req);
        if (req[s] && drdy) begin
            if (m_lock[inst]) begin
                if (eop[s]) m_lock[inst] = 1'b0;
            end else begin
                m_last[inst] = s;
                if (!eop[s]) begin
                    m_lock[inst]  = 1'b1;
                    m_owner[inst] = s;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_last  = '{3, 2};
            m_owner = '{0, 0};
            m_lock  = '{1'b0, 1'b0};
        end else begin
            model_step(0, c_srdy, c_eop, p_drdy);
            model_step(1, {1'b0, c3_srdy}, {1'b0, c3_eop}, p3_drdy);
        end
    end

    always @(negedge clk) begin
        int s;
        logic [3:0] ed;
        s = exp_sel(0, c_srdy);
        ed = '0; ed[s] = p_drdy;
        chk("tag4",  32'(p_tag),  32'(s));
        chk("srdy4", 32'(p_srdy), 32'(c_srdy[s]));
        chk("eop4",  32'(p_eop),  32'(c_eop[s]));
        chk("data4", 32'(p_data), 32'(c_data[s*8 +: 8]));
        chk("drdy4", 32'(c_drdy), 32'(ed));
        chk("lock4", 32'(p_lock), 32'(m_lock[0]));
        s = exp_sel(1, {1'b0, c3_srdy});
        ed = '0; ed[s] = p3_drdy;
        chk("tag3",  32'(p3_tag),  32'(s));
        chk("srdy3", 32'(p3_srdy), 32'(c3_srdy[s]));
        chk("eop3",  32'(p3_eop),  32'(c3_eop[s]));
        chk("data3", 32'(p3_data), 32'(c3_data[s*8 +: 8]));
        chk("drdy3", 32'(c3_drdy), 32'(ed[2:0]));
        chk("lock3", 32'(p3_lock), 32'(m_lock[1]));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [3:0] s, input logic [3:0] e, input logic d);
        c_srdy = s; c_eop = e; p_drdy = d; c_data = $urandom;
    endtask

    task automatic drive3(input logic [2:0] s, input logic [2:0] e, input logic d);
        c3_srdy = s; c3_eop = e; p3_drdy = d; c3_data = 24'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check tag/lock/drdy of the 4-input instance at the next falling edge.
    task automatic see(input string nm, input int tag, input int lock, input int drdy);
        @(negedge clk);
        chk({nm, "_tag"},  32'(p_tag),  32'(tag));
        chk({nm, "_lock"}, 32'(p_lock), 32'(lock));
        chk({nm, "_drdy"}, 32'(c_drdy), 32'(drdy));
        next_cycle();
    endtask

    task automatic see3(input string nm, input int tag, input int drdy);
        @(negedge clk);
        chk({nm, "_tag"},  32'(p3_tag),  32'(tag));
        chk({nm, "_drdy"}, 32'(c3_drdy), 32'(drdy));
        next_cycle();
    endtask

    initial begin
        int seq[5] = '{0, 1, 2, 3, 0};

        // reset state
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("rst_lock", 32'(p_lock), 0);
        chk("rst_tag",  32'(p_tag),  0);
        chk("rst_srdy", 32'(p_srdy), 0);
        chk("rst_tag3", 32'(p3_tag), 0);
        next_cycle();
        reset = 1'b1;

        // all requesting single-word packets: plain rotation
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b1);
            see("rot", seq[i], 0, 1 << seq[i]);
        end

        // 3-word packet from requester 1 while requester 2 waits
        drive(4'b0110, 4'b0100, 1'b1); see("pkt_w1", 1, 0, 4'b0010);
        drive(4'b0110, 4'b0100, 1'b1); see("pkt_w2", 1, 1, 4'b0010);
        drive(4'b0110, 4'b0110, 1'b1); see("pkt_w3", 1, 1, 4'b0010);
        drive(4'b0110, 4'b0110, 1'b1); see("pkt_nx", 2, 0, 4'b0100);

        // gap in a locked packet does not release the lock
        drive(4'b0010, 4'b0000, 1'b1); see("gap_w1", 1, 0, 4'b0010);
        for (int i = 0; i < 2; i++) begin
            drive(4'b0001, 4'b0001, 1'b1);
            @(negedge clk);
            chk("gap_srdy", 32'(p_srdy), 0);
            next_cycle();
            drive(4'b0001, 4'b0001, 1'b1);
        end
        drive(4'b0001, 4'b0001, 1'b1); see("gap_hold", 1, 1, 4'b0010);
        drive(4'b0011, 4'b0011, 1'b1); see("gap_end", 1, 1, 4'b0010);
        drive(4'b0001, 4'b0001, 1'b1); see("gap_nx", 0, 0, 4'b0001);

        // stalled: selection may move, nothing is committed
        drive(4'b0001, 4'b1111, 1'b0); see("stall_a", 0, 0, 0);
        drive(4'b0001, 4'b1111, 1'b0); see("stall_b", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 4'b1111, 1'b0); see("stall_c", 2, 0, 0);
        end
        drive(4'b1111, 4'b1111, 1'b1); see("stall_rel", 1, 0, 4'b0010);

        // reset in the middle of a packet locked to requester 3
        drive(4'b1000, 4'b0000, 1'b1); see("rlk_w1", 3, 0, 4'b1000);
        drive(4'b1000, 4'b0000, 1'b1); see("rlk_w2", 3, 1, 4'b1000);
        drive(4'b1001, 4'b1111, 1'b1);
        reset = 1'b0;
        #1;
        chk("rlk_lock_now", 32'(p_lock), 0);
        chk("rlk_tag_now",  32'(p_tag),  0);
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
        drive(4'b1001, 4'b1111, 1'b1); see("rlk_after", 0, 0, 4'b0001);
        drive(4'b0000, 4'b0000, 1'b0);

        // 3 requesters, rr_ptr starts at 2
        drive3(3'b001, 3'b111, 1'b0); see3("n3_r0", 0, 0);
        drive3(3'b100, 3'b111, 1'b0); see3("n3_r2", 2, 0);
        drive3(3'b010, 3'b111, 1'b0); see3("n3_r1", 1, 0);
        drive3(3'b111, 3'b111, 1'b1); see3("n3_a", 0, 3'b001);
        drive3(3'b111, 3'b111, 1'b1); see3("n3_b", 1, 3'b010);
        drive3(3'b111, 3'b111, 1'b1); see3("n3_c", 2, 3'b100);
        drive3(3'b111, 3'b111, 1'b1); see3("n3_wrap", 0, 3'b001);
        drive3(3'b000, 3'b000, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_fifo_sched.md
SD_FIFO_SCHED -- requirements
Module: sd_fifo_sched

Interface
REQ-001 SHALL have parameter `width`, default 8: data word width.
REQ-002 SHALL have parameter `inputs`, default 4: number of requesters; legal range 2..16, any value including non-power-of-2.
REQ-003 SHALL have parameter `isz`, default $clog2(inputs): tag width.
REQ-004 SHALL have port `clk`, input, 1 bit: single clock; all state updates on posedge.
REQ-005 SHALL have port `reset`, input, 1 bit: asynchronous, active-low; 0 resets the block.
REQ-006 SHALL have port `c_srdy`, input, `inputs` bits: per-requester word valid.
REQ-007 SHALL have port `c_drdy`, output, `inputs` bits: per-requester word accepted.
REQ-008 SHALL have port `c_data`, input, inputs*width bits: requester i occupies bits [i*width +: width].
REQ-009 SHALL have port `c_eop`, input, `inputs` bits: per-requester last word of packet.
REQ-010 SHALL have port `p_srdy`, output, 1 bit: word valid toward the shared FIFO c-side.
REQ-011 SHALL have port `p_drdy`, input, 1 bit: FIFO ready (FIFO c_drdy).
REQ-012 SHALL have port `p_data`, output, `width` bits: selected word.
REQ-013 SHALL have port `p_eop`, output, 1 bit: selected eop.
REQ-014 SHALL have port `p_tag`, output, `isz` bits: index of the selected requester.
REQ-015 SHALL have port `p_lock`, output, 1 bit: high while in S_LOCK.

Function
REQ-016 SHALL be a zero-latency pass-through: p_srdy = c_srdy[sel], p_data = c_data[sel], p_eop = c_eop[sel], p_tag = sel, c_drdy[sel] = p_drdy, and every other c_drdy bit = 0.
REQ-017 SHALL define a transfer as p_srdy & p_drdy, and SHALL never accept more than one word per cycle.
REQ-018 SHALL run a two-state FSM: S_IDLE (no packet in progress) and S_LOCK (mid-packet).
REQ-019 In S_IDLE, sel SHALL be the first requester with c_srdy=1, searching upward from rr_ptr+1 and wrapping from inputs-1 to 0.
REQ-020 In S_IDLE with no c_srdy bit set, sel SHALL equal rr_ptr+1 (wrapped) and p_srdy SHALL be 0.
REQ-021 A transfer in S_IDLE with p_eop=1 SHALL set rr_ptr to sel and leave the FSM in S_IDLE.
REQ-022 A transfer in S_IDLE with p_eop=0 SHALL set rr_ptr to sel, set lock_sel to sel and move the FSM to S_LOCK.
REQ-023 In S_LOCK, sel SHALL equal lock_sel regardless of any other requests; p_srdy SHALL follow c_srdy[lock_sel], and gaps in it SHALL NOT release the lock.
REQ-024 A transfer in S_LOCK with p_eop=1 SHALL return the FSM to S_IDLE; rr_ptr SHALL be unchanged.
REQ-025 Without a transfer, the FSM state, rr_ptr and lock_sel SHALL hold.
REQ-026 Arbitration SHALL be stall-fair: with p_drdy=0, sel in S_IDLE MAY change as c_srdy changes, and the grant SHALL be committed only on a transfer.
REQ-027 For non-power-of-2 `inputs`, rr_ptr and lock_sel SHALL never exceed inputs-1, and increments SHALL wrap explicitly.
REQ-028 A single-word packet (eop on the first word) SHALL never enter S_LOCK.

Reset
REQ-029 On reset=0, asynchronously: FSM = S_IDLE, rr_ptr = inputs-1 (so requester 0 has first priority), lock_sel = 0.
REQ-030 During reset, p_lock SHALL be 0, and p_srdy/c_drdy SHALL follow REQ-019/020 from the reset state.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the next grant SHALL follow REQ-019.

Structure
REQ-032 Shared package sd_sched_pkg SHALL hold the state typedef sched_state_t {S_IDLE, S_LOCK} and a helper function for the wrapped increment.
REQ-033 The rotating-priority search SHALL be a sub-module sd_rr_pick (inputs: req vector, ptr; outputs: sel, found), reusable by other arbiters.
REQ-034 State flops SHALL be rr_ptr, lock_sel and the FSM state only; the datapath SHALL hold no storage.

Verification
REQ-035 After reset, p_drdy=1, c_srdy=4'b1111, all eop=1 -> p_tag sequence 0,1,2,3,0.
REQ-036 Requester 1 sends a 3-word packet (eop on word 3) while requester 2 keeps c_srdy=1 -> p_tag=1 for 3 transfers, p_lock=1 after word 1 until word 3, then p_tag=2.
REQ-037 While locked to requester 1: c_srdy[1] drops for 2 cycles with requester 0 requesting -> p_srdy=0, c_drdy[0]=0 during the gap, lock held.
REQ-038 With inputs=3 and rr_ptr=2: request from requester 0 only -> sel=0; only requester 2 -> sel=2; rr_ptr never reaches 3.
REQ-039 With p_drdy=0 for 5 cycles while c_srdy changes 0001 -> 0100 -> rr_ptr stays unchanged and no c_drdy bit goes high.
REQ-040 Reset asserted mid-packet while locked to requester 3 -> p_lock=0 immediately, and the next transfer grants requester 0 when it requests.
